// File: rtl/dec16_onehot_seq_if.sv
// Handshake and line-bus bundle for dec16_onehot_seq.
// The parity pair exists only when DEC16_PARITY_EN is defined.
interface dec16_onehot_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic        en;
  logic [15:0] d;
  logic        d_valid;
  logic        busy;
`ifdef DEC16_PARITY_EN
  logic        in_par;
  logic        par_err;

  modport master (output in_valid, in_code, in_par, en,
                  input  in_ready, d, d_valid, busy, par_err);
  modport slave  (input  in_valid, in_code, in_par, en,
                  output in_ready, d, d_valid, busy, par_err);
`else
  modport master (output in_valid, in_code, en,
                  input  in_ready, d, d_valid, busy);
  modport slave  (input  in_valid, in_code, en,
                  output in_ready, d, d_valid, busy);
`endif
endinterface

// File: rtl/dec16_onehot_seq.sv
// Sequenced 4-to-16 one-hot decoder: 2-entry code FIFO feeding a line driver
// that holds each one-hot word for HOLD enabled cycles. Optional DEC16_PARITY_EN.
module dec16_onehot_seq #(
  parameter int unsigned HOLD = 1
) (
  input logic               clk,
  input logic               rst_n,
  dec16_onehot_seq_if.slave bus
);

  typedef enum logic {S_IDLE, S_DRIVE} state_e;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_e      state_q;
  logic [3:0]  fifo_mem [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  occ_q;
  logic [7:0]  hold_cnt_q;
  logic [15:0] d_q;
  logic        d_valid_q;
  logic        accept;
  logic        store;
  logic        pop;
  logic        fifo_empty;
  logic [3:0]  head_code;

  assign fifo_empty   = (occ_q == 2'd0);
  assign head_code    = fifo_mem[rd_ptr_q];
  // NOTE: in_ready looks only at registered occupancy, so a full FIFO never accepts even when it pops.
  assign bus.in_ready = (occ_q != 2'd2);
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef DEC16_PARITY_EN
  logic par_ok;
  logic par_err_q;

  assign par_ok      = ~^{bus.in_par, bus.in_code};
  assign store       = accept && par_ok;
  assign bus.par_err = par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= accept && !par_ok;
  end
`else
  assign store = accept;
`endif

  // Pop whenever the driver is free: idle, or on the last enabled cycle of a word.
  assign pop = bus.en && !fifo_empty && ((state_q == S_IDLE) || (hold_cnt_q == 8'd0));

  // NOTE: FIFO storage is deliberately not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (store) fifo_mem[wr_ptr_q] <= bus.in_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (store) wr_ptr_q <= ~wr_ptr_q;
      if (pop)   rd_ptr_q <= ~rd_ptr_q;
      case ({store, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= 8'd0;
      d_q        <= 16'h0000;
      d_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            d_q        <= 16'h0001 << head_code;
            d_valid_q  <= 1'b1;
            hold_cnt_q <= HOLD_M1;
            state_q    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (bus.en) begin
            if (hold_cnt_q != 8'd0) begin
              hold_cnt_q <= hold_cnt_q - 8'd1;
            end else if (pop) begin
              d_q        <= 16'h0001 << head_code;
              hold_cnt_q <= HOLD_M1;
            end else begin
              d_q       <= 16'h0000;
              d_valid_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.d       = d_q;
  assign bus.d_valid = d_valid_q;
  assign bus.busy    = !fifo_empty || (state_q == S_DRIVE);

endmodule

// File: tb/tb_dec16_onehot_seq.sv
// Drives four decoders (HOLD = 1..4) with shared stimulus and compares each
// against a queue-based model of the line-driving behaviour.
module tb_dec16_onehot_seq;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_valid;
  logic [3:0] tb_code;
  logic       tb_en;
`ifdef DEC16_PARITY_EN
  logic       tb_par;
`endif

  logic [15:0] obs_d    [N];
  logic        obs_dv   [N];
  logic        obs_rdy  [N];
  logic        obs_busy [N];
`ifdef DEC16_PARITY_EN
  logic        obs_perr [N];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dec16_onehot_seq_if u_if ();
    assign u_if.in_valid = tb_valid;
    assign u_if.in_code  = tb_code;
    assign u_if.en       = tb_en;
    assign obs_d[g]      = u_if.d;
    assign obs_dv[g]     = u_if.d_valid;
    assign obs_rdy[g]    = u_if.in_ready;
    assign obs_busy[g]   = u_if.busy;
`ifdef DEC16_PARITY_EN
    assign u_if.in_par   = tb_par;
    assign obs_perr[g]   = u_if.par_err;
`endif
    dec16_onehot_seq #(.HOLD(g + 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
    );
  end

  // Reference model: pending codes, word on the bus (-1 = none), enabled cycles left.
  logic [3:0] mq   [N][$];
  int         cur  [N];
  int         rem  [N];
  logic       mperr[N];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      cur[i]   = -1;
      rem[i]   = 0;
      mperr[i] = 1'b0;
    end
  endtask

  // Advance the model by one rising edge using the inputs presented before it.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      automatic bit ready = (mq[i].size() < 2);
      automatic bit acc   = tb_valid && ready;
      automatic bit ok    = 1'b1;
`ifdef DEC16_PARITY_EN
      ok = ~^{tb_par, tb_code};
`endif
      if (cur[i] < 0) begin
        if (tb_en && mq[i].size() > 0) begin
          cur[i] = int'(mq[i].pop_front());
          rem[i] = i + 1;
        end
      end else if (tb_en) begin
        rem[i]--;
        if (rem[i] == 0) begin
          if (mq[i].size() > 0) begin
            cur[i] = int'(mq[i].pop_front());
            rem[i] = i + 1;
          end else begin
            cur[i] = -1;
          end
        end
      end
      if (acc && ok) mq[i].push_back(tb_code);
      mperr[i] = acc && !ok;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++) begin
      automatic logic [15:0] exp_d = (cur[i] < 0) ? 16'h0000 : (16'h0001 << cur[i]);
      check($sformatf("%s.h%0d.d", tag, i + 1), 32'(obs_d[i]), 32'(exp_d));
      check($sformatf("%s.h%0d.d_valid", tag, i + 1), 32'(obs_dv[i]), 32'(cur[i] >= 0));
      check($sformatf("%s.h%0d.in_ready", tag, i + 1), 32'(obs_rdy[i]), 32'(mq[i].size() < 2));
      check($sformatf("%s.h%0d.busy", tag, i + 1), 32'(obs_busy[i]),
            32'((mq[i].size() > 0) || (cur[i] >= 0)));
`ifdef DEC16_PARITY_EN
      check($sformatf("%s.h%0d.par_err", tag, i + 1), 32'(obs_perr[i]), 32'(mperr[i]));
`endif
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic drain();
    tb_valid = 1'b0;
    tb_en    = 1'b1;
    repeat (16) step("drain");
  endtask

  logic [15:0] log_q[$];
  int          cnt;
  int          guard;
  bit          accepted;
  bit          was_ready;
  bit          saw_not_ready;

  initial begin
    rst_n    = 1'b0;
    tb_valid = 1'b0;
    tb_code  = 4'd0;
    tb_en    = 1'b1;
`ifdef DEC16_PARITY_EN
    tb_par   = 1'b0;
`endif
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single decode; HOLD = 3 instance drives 0x0020 for three cycles.
    tb_valid = 1'b1; tb_code = 4'd5;
    step("single_push");
    check("single.h3.latency", 32'(obs_d[2]), 32'h0);
    tb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("single_drive");
      check("single.h3.word", 32'(obs_d[2]), 32'h0020);
    end
    step("single_end");
    check("single.h3.idle", 32'(obs_d[2]), 32'h0);
    drain();

    // Back-to-back on HOLD = 1: no zero gap, in_ready stays high.
    tb_valid = 1'b1; tb_code = 4'd0;
    step("b2b_push0");
    check("b2b.h1.ready0", 32'(obs_rdy[0]), 32'h1);
    tb_code = 4'd15;
    step("b2b_push15");
    check("b2b.h1.w0", 32'(obs_d[0]), 32'h0001);
    check("b2b.h1.ready1", 32'(obs_rdy[0]), 32'h1);
    tb_code = 4'd7;
    step("b2b_push7");
    check("b2b.h1.w15", 32'(obs_d[0]), 32'h8000);
    check("b2b.h1.ready2", 32'(obs_rdy[0]), 32'h1);
    tb_valid = 1'b0;
    step("b2b_tail");
    check("b2b.h1.w7", 32'(obs_d[0]), 32'h0080);
    drain();

    // Backpressure on HOLD = 4: codes 1..4 offered with in_valid held high.
    log_q.delete();
    saw_not_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tb_valid = 1'b1;
      tb_code  = 4'(k);
      accepted = 1'b0;
      guard    = 0;
      while (!accepted && guard < 40) begin
        was_ready = obs_rdy[3];
        if (!was_ready) saw_not_ready = 1'b1;
        step("bp_offer");
        if (obs_d[3] != 16'h0) log_q.push_back(obs_d[3]);
        accepted = was_ready;
        guard++;
      end
      check($sformatf("bp.h4.accept%0d", k), 32'(accepted), 32'h1);
    end
    tb_valid = 1'b0;
    repeat (24) begin
      step("bp_drain");
      if (obs_d[3] != 16'h0) log_q.push_back(obs_d[3]);
    end
    check("bp.h4.saw_not_ready", 32'(saw_not_ready), 32'h1);
    check("bp.h4.word_cycles", 32'(log_q.size()), 32'd16);
    for (int j = 0; j < 16 && j < log_q.size(); j++)
      check($sformatf("bp.h4.seq%0d", j), 32'(log_q[j]), 32'(16'h0001 << (j / 4 + 1)));
    drain();

    // Enable stall on HOLD = 2: code 9 held 2 + 5 cycles; queued code 2 waits.
    cnt = 0;
    tb_valid = 1'b1; tb_code = 4'd9;
    step("stall_push");
    tb_code = 4'd2;
    step("stall_load");
    if (obs_d[1] == 16'h0200) cnt++;
    tb_valid = 1'b0;
    tb_en = 1'b0;
    repeat (5) begin
      step("stall_frozen");
      if (obs_d[1] == 16'h0200) cnt++;
    end
    tb_en = 1'b1;
    repeat (8) begin
      step("stall_resume");
      if (obs_d[1] == 16'h0200) cnt++;
    end
    check("stall.h2.cycles", 32'(cnt), 32'd7);
    drain();

    // Asynchronous reset mid-word with a code still queued.
    tb_valid = 1'b1; tb_code = 4'd5;
    step("rst_push5");
    tb_code = 4'd6;
    step("rst_push6");
    tb_valid = 1'b0;
    check("rst.h3.pre_word", 32'(obs_d[2]), 32'h0020);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.h3.d", 32'(obs_d[2]), 32'h0);
    check("rst.h3.busy", 32'(obs_busy[2]), 32'h0);
    check("rst.h3.ready", 32'(obs_rdy[2]), 32'h1);
    compare_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      step("rst_after");
      check("rst.h3.no_stale", 32'(obs_dv[2]), 32'h0);
    end

`ifdef DEC16_PARITY_EN
    // Bad parity drops the code and pulses par_err; good parity decodes.
    tb_valid = 1'b1; tb_code = 4'd3; tb_par = 1'b1;
    step("par_bad");
    check("par.h1.err_pulse", 32'(obs_perr[0]), 32'h1);
    tb_valid = 1'b0; tb_par = 1'b0;
    step("par_after");
    check("par.h1.err_clear", 32'(obs_perr[0]), 32'h0);
    check("par.h1.dropped", 32'(obs_d[0]), 32'h0);
    tb_valid = 1'b1;
    step("par_good");
    tb_valid = 1'b0;
    step("par_word");
    check("par.h1.word", 32'(obs_d[0]), 32'h0008);
    drain();
`endif

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      tb_valid = ($urandom_range(0, 9) < 7);
      tb_code  = 4'($urandom_range(0, 15));
      tb_en    = ($urandom_range(0, 9) < 8);
`ifdef DEC16_PARITY_EN
      tb_par   = (^tb_code) ^ ($urandom_range(0, 9) == 0);
`endif
      step("random");
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
